cbfp_block_scaler: RTL and testbench
====================================

// Module: cbfp_block_scaler
// PURPOSE
//   Consumer side of the CBFP reorder buffer. Takes the 16-lane beats read out of the
//   block buffer and applies one block exponent (normalising left shift) per 64-sample block.
//   Narrows each lane from DIN_SIZE to DOUT_SIZE with saturation, which yields the next FFT stage's input.
//   Emits the applied exponent alongside the data for downstream exponent accumulation.
// PARAMETERS
//   ARRAY_SIZE   16  lanes per beat
//   DIN_SIZE     23  signed input lane width
//   DOUT_SIZE    11  signed output lane width (must be < DIN_SIZE)
//   BUFFER_DEPTH 64  samples per CBFP block; BEATS = BUFFER_DEPTH/ARRAY_SIZE (4)
//   SHIFT_W      5   width of shift_in, = $clog2(DIN_SIZE)
// PORTS
//   clk         in   1                   clock, all logic on posedge
//   rstn        in   1                   asynchronous active-low reset
//   valid_in    in   1                   beat valid; gaps allowed between beats
//   din         in   DIN_SIZE x ARRAY_SIZE  signed lanes [0:ARRAY_SIZE-1]
//   shift_valid in   1                   block exponent present; sampled on block's first beat only
//   shift_in    in   SHIFT_W             left-shift amount (redundant sign bits) for block
//   dout        out  DOUT_SIZE x ARRAY_SIZE signed scaled lanes
//   valid_out   out  1                   dout/exp_out valid
//   exp_out     out  SHIFT_W             shift applied to current output beat
//   blk_first   out  1                   output beat is beat 0 of block
//   blk_last    out  1                   output beat is beat BEATS-1 of block
//   sat_out     out  1                   >=1 lane of this beat saturated
//   shift_err   out  1                   first beat arrived without shift_valid
// BEHAVIOUR
//   - Reset: dout all 0, valid_out/blk_first/blk_last/sat_out/shift_err 0, exp_out 0,
//     beat counter 0, held shift 0, pipeline valids cleared. Reset mid-block aborts block
//     and the next valid_in is beat 0.
//   - Beat counter 0..BEATS-1 advances only on valid_in, wraps BEATS-1 -> 0.
//   - On valid_in with cnt==0: shift_valid=1 -> shift_in latched and used for all BEATS beats;
//     shift_valid=0 -> previous held shift reused, shift_err=1 on that beat's output.
//     shift_valid on cnt!=0 is ignored. shift_in > DIN_SIZE-1 is clamped to DIN_SIZE-1.
//   - Datapath, two register stages, latency 2 cycles valid_in -> valid_out; fully
//     pipelined, one beat per cycle, no back-pressure. Tags (exp, first/last, err) travel with data.
//     S1: y = x <<< s in DIN_SIZE+DIN_SIZE bits; ovf if y outside signed DIN_SIZE range.
//     S2: drop D = DIN_SIZE-DOUT_SIZE LSBs (arithmetic), saturate to
//         [-(2^(DOUT_SIZE-1)), 2^(DOUT_SIZE-1)-1]; ovf forces saturation toward sign of x.
//   - sat_out = OR of per-lane saturation, same cycle as dout. Zero input never saturates.
//   - With valid_out=0, dout holds last value (not cleared); flags are 0.
// CONFIGURATION
//   CBFP_ROUND_EN defined: S2 adds 2^(D-1) before dropping D bits (round half up), then
//     saturates; rounding carry past max -> saturate, sat_out=1.
//   Not defined: plain truncation (floor), no adder; latency unchanged (2).
// STRUCTURE
//   cbfp_pkg: ARRAY_SIZE/DIN_SIZE/DOUT_SIZE/BUFFER_DEPTH defaults, BEATS, SHIFT_W,
//     typedefs din_t, dout_t, shift_t, and a sat_limits function for DOUT_SIZE.
//   Sub-module cbfp_lane_shift: one lane S1+S2 (shift, ovf detect, round, saturate),
//     instantiated ARRAY_SIZE times by generate; top holds counter, shift latch, tag pipeline.
// TESTING (defaults, D=12)
//   1) 4 beats, cnt0 shift_valid=1 shift_in=20, all lanes x=3 -> dout=768 each beat, exp_out=20,
//      blk_first on beat 0, blk_last on beat 3, valid_out 2 cycles after each valid_in.
//   2) x=2048 shift 0 -> dout=0 without CBFP_ROUND_EN, 1 with it; x=-1 shift 0 -> -1 / 0.
//   3) x=4194303 shift 1 -> dout=1023, sat_out=1; x=-4194304 shift 0 -> -1024, sat_out=0.
//   4) Block 2 first beat with shift_valid=0 after block 1 shift=7 -> exp_out=7, shift_err=1
//      on that beat only; shift_valid=1 shift_in=3 on beat 2 ignored.
//   5) Gapped valid_in (1 idle cycle between beats) over 2 blocks -> counter/tag alignment
//      intact, blk_last on every 4th output; shift_in=31 clamped -> exp_out=22.
//   6) rstn low after beat 2 of a block -> all outputs 0 asynchronously; next beat is
//      blk_first and requires shift_valid.

Source files
------------

// File: rtl/cbfp_pkg.sv
// Shared sizes, lane types and saturation limits for the CBFP block scaler.
package cbfp_pkg;

   localparam int unsigned ARRAY_SIZE   = 16;
   localparam int unsigned DIN_SIZE     = 23;
   localparam int unsigned DOUT_SIZE    = 11;
   localparam int unsigned BUFFER_DEPTH = 64;
   localparam int unsigned BEATS        = BUFFER_DEPTH / ARRAY_SIZE;
   localparam int unsigned SHIFT_W      = $clog2(DIN_SIZE);
   localparam int unsigned CNT_W        = $clog2(BEATS);
   localparam int unsigned DROP_W       = DIN_SIZE - DOUT_SIZE;

   typedef logic signed [DIN_SIZE-1:0]  din_t;
   typedef logic signed [DOUT_SIZE-1:0] dout_t;
   typedef logic        [SHIFT_W-1:0]   shift_t;

   // Tags that travel alongside each beat through the datapath
   typedef struct packed {
      shift_t exp;
      logic   first;
      logic   last;
      logic   err;
   } beat_tag_t;

   // Most negative output code for neg=1, most positive otherwise
   function automatic dout_t sat_limits(input logic neg);
      return neg ? {1'b1, {(DOUT_SIZE-1){1'b0}}} : {1'b0, {(DOUT_SIZE-1){1'b1}}};
   endfunction

endpackage

// File: rtl/cbfp_lane_shift.sv
// One lane of the block scaler: normalising shift with overflow detect, then narrowing.
// CBFP_ROUND_EN selects round-half-up narrowing; otherwise the dropped bits are truncated.
module cbfp_lane_shift
   import cbfp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en1_i,
   input  logic                 en2_i,
   input  logic [DIN_SIZE-1:0]  x_i,
   input  logic [SHIFT_W-1:0]   s_i,
   output logic [DOUT_SIZE-1:0] y_o,
   output logic                 sat_c
);

   localparam int unsigned WIDE_W = 2 * DIN_SIZE;
   localparam int unsigned Q_W    = DIN_SIZE - DROP_W + 1;

   logic signed [WIDE_W-1:0] wide_c;
   logic                     ovf_c;
   logic signed [Q_W-1:0]    q_c;
   dout_t                    sel_c;
`ifdef CBFP_ROUND_EN
   logic signed [DIN_SIZE:0] rnd_c;
`endif

   din_t  y1_q, y1_d;
   logic  ovf1_q, ovf1_d;
   logic  neg1_q, neg1_d;
   dout_t y2_q, y2_d;

   always_comb begin
      wide_c = WIDE_W'(din_t'(x_i)) <<< s_i;
      // Shift result fits only if every bit above the input sign position matches it
      ovf_c  = !((&wide_c[WIDE_W-1:DIN_SIZE-1]) || !(|wide_c[WIDE_W-1:DIN_SIZE-1]));
      y1_d   = en1_i ? wide_c[DIN_SIZE-1:0] : y1_q;
      ovf1_d = en1_i ? ovf_c : ovf1_q;
      neg1_d = en1_i ? x_i[DIN_SIZE-1] : neg1_q;

`ifdef CBFP_ROUND_EN
      rnd_c = {y1_q[DIN_SIZE-1], y1_q} + (DIN_SIZE+1)'(1 << (DROP_W - 1));
      q_c   = Q_W'(rnd_c >>> DROP_W);
`else
      q_c   = Q_W'(y1_q >>> DROP_W);
`endif

      sat_c = 1'b0;
      sel_c = DOUT_SIZE'(q_c);
      if (ovf1_q) begin
         sat_c = 1'b1;
         sel_c = sat_limits(neg1_q);
      end else if (q_c > Q_W'(sat_limits(1'b0))) begin
         sat_c = 1'b1;
         sel_c = sat_limits(1'b0);
      end else if (q_c < Q_W'(sat_limits(1'b1))) begin
         sat_c = 1'b1;
         sel_c = sat_limits(1'b1);
      end
      y2_d = en2_i ? sel_c : y2_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         y1_q   <= '0;
         ovf1_q <= 1'b0;
         neg1_q <= 1'b0;
         y2_q   <= '0;
      end else begin
         y1_q   <= y1_d;
         ovf1_q <= ovf1_d;
         neg1_q <= neg1_d;
         y2_q   <= y2_d;
      end
   end

   assign y_o = y2_q;

endmodule

// File: rtl/cbfp_block_scaler.sv
// Applies one latched block exponent to each 4-beat CBFP block and narrows lanes with saturation.
// Optional CBFP_ROUND_EN (inside cbfp_lane_shift) switches narrowing from truncation to rounding.
module cbfp_block_scaler
   import cbfp_pkg::*;
(
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            valid_in,
   input  logic [ARRAY_SIZE*DIN_SIZE-1:0]  din,
   input  logic                            shift_valid,
   input  logic [SHIFT_W-1:0]              shift_in,
   output logic [ARRAY_SIZE*DOUT_SIZE-1:0] dout,
   output logic                            valid_out,
   output logic [SHIFT_W-1:0]              exp_out,
   output logic                            blk_first,
   output logic                            blk_last,
   output logic                            sat_out,
   output logic                            shift_err
);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   shift_t                shift_q, shift_d;
   logic                  v1_q, v1_d;
   beat_tag_t             tag1_q, tag1_d;
   logic                  valid_q, valid_d;
   shift_t                exp_q, exp_d;
   logic                  first_q, first_d;
   logic                  last_q, last_d;
   logic                  sat_q, sat_d;
   logic                  err_q, err_d;

   shift_t                clamp_c;
   shift_t                eff_c;
   logic                  first_c;
   logic                  last_c;
   logic                  take_c;
   logic [ARRAY_SIZE-1:0] lane_sat_c;

   always_comb begin
      clamp_c = (shift_in > SHIFT_W'(DIN_SIZE - 1)) ? SHIFT_W'(DIN_SIZE - 1) : shift_in;
      first_c = (cnt_q == '0);
      last_c  = (cnt_q == CNT_W'(BEATS - 1));
      // The exponent is only accepted on a block's first beat; later beats reuse the held value
      take_c  = valid_in && first_c && shift_valid;
      eff_c   = take_c ? clamp_c : shift_q;
      shift_d = eff_c;

      cnt_d = cnt_q;
      if (valid_in) begin
         cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
      end

      v1_d   = valid_in;
      tag1_d = tag1_q;
      if (valid_in) begin
         tag1_d = '{exp: eff_c, first: first_c, last: last_c, err: first_c && !shift_valid};
      end

      valid_d = v1_q;
      exp_d   = v1_q ? tag1_q.exp : '0;
      first_d = v1_q && tag1_q.first;
      last_d  = v1_q && tag1_q.last;
      err_d   = v1_q && tag1_q.err;
      sat_d   = v1_q && (|lane_sat_c);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q   <= '0;
         shift_q <= '0;
         v1_q    <= 1'b0;
         tag1_q  <= '0;
         valid_q <= 1'b0;
         exp_q   <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         v1_q    <= v1_d;
         tag1_q  <= tag1_d;
         valid_q <= valid_d;
         exp_q   <= exp_d;
         first_q <= first_d;
         last_q  <= last_d;
         sat_q   <= sat_d;
         err_q   <= err_d;
      end
   end

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      cbfp_lane_shift u_lane (
         .clk   (clk),
         .rstn  (rstn),
         .en1_i (valid_in),
         .en2_i (v1_q),
         .x_i   (din[i*DIN_SIZE +: DIN_SIZE]),
         .s_i   (eff_c),
         .y_o   (dout[i*DOUT_SIZE +: DOUT_SIZE]),
         .sat_c (lane_sat_c[i])
      );
   end

   assign valid_out = valid_q;
   assign exp_out   = exp_q;
   assign blk_first = first_q;
   assign blk_last  = last_q;
   assign sat_out   = sat_q;
   assign shift_err = err_q;

endmodule

// File: tb/tb_cbfp_block_scaler.sv
// Bench for cbfp_block_scaler: directed block scenarios plus randomized beats against an arithmetic model.
module tb_cbfp_block_scaler;

   localparam int NL = 16;
   localparam int DW = 23;
   localparam int OW = 11;

   logic              clk = 1'b0;
   logic              rstn;
   logic              valid_in;
   logic [NL*DW-1:0]  din;
   logic              shift_valid;
   logic [4:0]        shift_in;
   logic [NL*OW-1:0]  dout;
   logic              valid_out;
   logic [4:0]        exp_out;
   logic              blk_first;
   logic              blk_last;
   logic              sat_out;
   logic              shift_err;

   cbfp_block_scaler dut (
      .clk         (clk),
      .rstn        (rstn),
      .valid_in    (valid_in),
      .din         (din),
      .shift_valid (shift_valid),
      .shift_in    (shift_in),
      .dout        (dout),
      .valid_out   (valid_out),
      .exp_out     (exp_out),
      .blk_first   (blk_first),
      .blk_last    (blk_last),
      .sat_out     (sat_out),
      .shift_err   (shift_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NL*OW-1:0] d;
      logic [4:0]       e;
      logic             f;
      logic             l;
      logic             s;
      logic             r;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_cnt = 0;
   int   m_shift = 0;
   logic [1:0] vpipe;

   task automatic chk(input string nm, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
      end
   endtask

   // Value-level reference: scale by 2^s, saturate if the scaled value leaves the input range,
   // then divide by 4096 (floor, or round half up) and clip to the output range.
   function automatic int lane_model(input longint x, input int s, output bit sat);
      longint y;
      longint r;
      y   = x * (longint'(1) << s);
      sat = 1'b1;
      if (y > 64'sd4194303) return 1023;
      if (y < -64'sd4194304) return -1024;
`ifdef CBFP_ROUND_EN
      y = y + 2048;
`endif
      r = (y >= 0) ? y / 4096 : -((-y + 4095) / 4096);
      if (r > 1023) return 1023;
      if (r < -1024) return -1024;
      sat = 1'b0;
      return int'(r);
   endfunction

   function automatic logic [NL*DW-1:0] fill(input int val);
      logic [NL*DW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(val);
      return r;
   endfunction

   function automatic logic [NL*DW-1:0] rand_beat();
      logic [NL*DW-1:0] r;
      int v;
      for (int i = 0; i < NL; i++) begin
         case ($urandom % 6)
            0: v = 0;
            1: v = int'($urandom % 32'h0080_0000) - 4194304;
            2: v = int'($urandom_range(0, 63)) - 32;
            3: v = 4194303;
            4: v = -4194304;
            default: v = int'($urandom_range(0, 8191)) - 4096;
         endcase
         r[i*DW +: DW] = DW'(v);
      end
      return r;
   endfunction

   // Drive one beat at a negedge and queue what the outputs must be for it
   task automatic drive_beat(input logic [NL*DW-1:0] d, input bit sv, input int sin);
      exp_t                  e;
      bit                    s;
      bit                    first;
      int                    v;
      logic signed [DW-1:0]  xl;
      first = (m_cnt == 0);
      if (first && sv) m_shift = (sin > 22) ? 22 : sin;
      e.e = m_shift[4:0];
      e.f = first;
      e.l = (m_cnt == 3);
      e.r = first && !sv;
      e.s = 1'b0;
      for (int i = 0; i < NL; i++) begin
         xl = d[i*DW +: DW];
         v  = lane_model(longint'(xl), m_shift, s);
         e.d[i*OW +: OW] = v[OW-1:0];
         e.s = e.s | s;
      end
      valid_in    = 1'b1;
      din         = d;
      shift_valid = sv;
      shift_in    = sin[4:0];
      q.push_back(e);
      m_cnt = (m_cnt + 1) % 4;
      @(negedge clk);
      valid_in    = 1'b0;
      shift_valid = 1'($urandom % 2);
      shift_in    = 5'($urandom);
      din         = rand_beat();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_dout"}, longint'(dout == '0), 1);
      chk({tag, "_valid"}, valid_out, 0);
      chk({tag, "_exp"}, exp_out, 0);
      chk({tag, "_flags"}, {blk_first, blk_last, sat_out, shift_err}, 0);
   endtask

   // Async reset in the middle of the low clock phase, then release away from edges
   task automatic do_reset();
      #2 rstn = 1'b0;
      #1 check_all_zero("async_rst");
      q.delete();
      m_cnt   = 0;
      m_shift = 0;
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) vpipe <= 2'b00;
      else       vpipe <= {vpipe[0], valid_in};
   end

   // Output checker: every cycle out of reset
   initial begin
      exp_t e;
      logic signed [OW-1:0] a;
      logic signed [OW-1:0] b;
      forever begin
         @(negedge clk);
         if (rstn) begin
            chk("valid_out", valid_out, vpipe[1]);
            if (vpipe[1]) begin
               if (q.size() == 0) begin
                  chk("queue_underflow", 1, 0);
               end else begin
                  e = q.pop_front();
                  for (int i = 0; i < NL; i++) begin
                     a = dout[i*OW +: OW];
                     b = e.d[i*OW +: OW];
                     chk($sformatf("dout[%0d]", i), a, b);
                  end
                  chk("exp_out", exp_out, e.e);
                  chk("blk_first", blk_first, e.f);
                  chk("blk_last", blk_last, e.l);
                  chk("sat_out", sat_out, e.s);
                  chk("shift_err", shift_err, e.r);
               end
            end else begin
               chk("idle_flags", {blk_first, blk_last, sat_out, shift_err}, 0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit s;
      logic [NL*DW-1:0] mix;
      rstn        = 1'b1;
      valid_in    = 1'b0;
      din         = '0;
      shift_valid = 1'b0;
      shift_in    = '0;

      // Hand-computed anchors for the reference model
      chk("pin_x3_s20", lane_model(3, 20, s), 768);
      chk("pin_max_s1", lane_model(4194303, 1, s), 1023);
      chk("pin_max_s1_sat", s, 1);
      chk("pin_min_s0", lane_model(-4194304, 0, s), -1024);
      chk("pin_min_s0_sat", s, 0);
      chk("pin_zero_s22", lane_model(0, 22, s), 0);
`ifdef CBFP_ROUND_EN
      chk("pin_2048", lane_model(2048, 0, s), 1);
      chk("pin_m1", lane_model(-1, 0, s), 0);
      chk("pin_rnd_carry", lane_model(4194303, 0, s), 1023);
      chk("pin_rnd_carry_sat", s, 1);
`else
      chk("pin_2048", lane_model(2048, 0, s), 0);
      chk("pin_m1", lane_model(-1, 0, s), -1);
      chk("pin_trunc_max", lane_model(4194303, 0, s), 1023);
      chk("pin_trunc_max_sat", s, 0);
`endif

      #2 rstn = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);

      // Uniform block with a single exponent
      drive_beat(fill(3), 1'b1, 20);
      for (int b = 1; b < 4; b++) drive_beat(fill(3), 1'b0, 0);

      // Narrowing boundaries at shift 0, then overflow at shift 1
      mix = fill(2048);
      mix[DW +: DW]     = DW'(-1);
      mix[2*DW +: DW]   = DW'(-4194304);
      mix[3*DW +: DW]   = DW'(4194303);
      drive_beat(mix, 1'b1, 0);
      drive_beat(fill(-1), 1'b0, 0);
      drive_beat(fill(-4194304), 1'b1, 9);
      drive_beat(fill(2048), 1'b0, 0);
      drive_beat(fill(4194303), 1'b1, 1);
      drive_beat(fill(-4194304), 1'b0, 0);
      drive_beat(fill(-4194304), 1'b0, 0);
      drive_beat(fill(0), 1'b0, 0);

      // Missing exponent reuses the previous block's; mid-block exponent ignored
      for (int b = 0; b < 4; b++) drive_beat(rand_beat(), b == 0, 7);
      for (int b = 0; b < 4; b++) drive_beat(rand_beat(), b == 2, 3);

      // Gapped beats over two blocks, out-of-range exponent clamps
      for (int b = 0; b < 8; b++) begin
         drive_beat(fill(1), b % 4 == 0, 31);
         @(negedge clk);
      end

      // Reset mid-block, then blocks with and without an exponent after it
      for (int b = 0; b < 3; b++) drive_beat(rand_beat(), b == 0, 5);
      do_reset();
      for (int b = 0; b < 4; b++) drive_beat(fill(5), b == 0, 4);
      drive_beat(fill(6), 1'b1, 2);
      drive_beat(fill(6), 1'b0, 0);
      do_reset();
      for (int b = 0; b < 4; b++) drive_beat(fill(-5), 1'b0, 9);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         if ($urandom % 4 == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
         drive_beat(rand_beat(), (m_cnt == 0) ? ($urandom % 10 != 0) : 1'($urandom % 2),
                    int'($urandom_range(0, 31)));
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
